// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared widths and ALU opcode encoding for datapath_unit
package datapath_pkg;

  localparam int DW    = 16;
  localparam int RF_AW = 4;
  localparam int DM_AW = 8;

  typedef enum logic [2:0] {
    ALU_ZERO  = 3'b000,
    ALU_ADD   = 3'b001,
    ALU_SUB   = 3'b010,
    ALU_PASSA = 3'b011,
    ALU_XOR   = 3'b100,
    ALU_OR    = 3'b101,
    ALU_AND   = 3'b110,
    ALU_INC   = 3'b111
  } alu_op_e;

endpackage

// File: rtl/register_file.sv
// rtl/register_file.sv - 16x16 register file, two combinational read ports, one write port
// Asynchronous clear; a write is visible on the read ports from the following cycle.
module register_file
  import datapath_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [RF_AW-1:0] waddr,
  input  logic [DW-1:0]    wdata,
  input  logic [RF_AW-1:0] raddr_a,
  input  logic [RF_AW-1:0] raddr_b,
  output logic [DW-1:0]    rdata_a,
  output logic [DW-1:0]    rdata_b
);

  localparam int DEPTH = 1 << RF_AW;

  logic [DW-1:0] regs_q [DEPTH];
  logic [DW-1:0] regs_d [DEPTH];

  always_comb begin
    regs_d = regs_q;
    if (we) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata_a = regs_q[raddr_a];
  assign rdata_b = regs_q[raddr_b];

endmodule

// File: rtl/datapath_unit.sv
// rtl/datapath_unit.sv - register file, ALU, 256-word data memory and write-back mux
// Optional Z/N/C flag outputs are built when DATAPATH_FLAGS_EN is defined.
module datapath_unit
  import datapath_pkg::*;
(
  input  logic             Clk,
  input  logic             Rst,
  input  logic [DM_AW-1:0] D_Addr,
  input  logic             D_Wr,
  input  logic             RF_s,
  input  logic             RF_W_en,
  input  logic [RF_AW-1:0] RF_W_Addr,
  input  logic [RF_AW-1:0] RF_Ra_Addr,
  input  logic [RF_AW-1:0] RF_Rb_Addr,
  input  logic [2:0]       Alu_s0,
  output logic [DW-1:0]    Ra_Data,
  output logic [DW-1:0]    Rb_Data,
  output logic [DW-1:0]    ALU_Out,
  output logic [DW-1:0]    W_Data
`ifdef DATAPATH_FLAGS_EN
  ,
  output logic             Z,
  output logic             N,
  output logic             C
`endif
);

  localparam int DM_DEPTH = 1 << DM_AW;

  alu_op_e       alu_op;
  logic [DW-1:0] alu_res;
  logic [DW-1:0] q_q, q_d;
  logic [DW-1:0] mem [DM_DEPTH];
  logic          mem_we;

  assign alu_op = alu_op_e'(Alu_s0);

  register_file u_rf (
    .clk     (Clk),
    .rst     (Rst),
    .we      (RF_W_en),
    .waddr   (RF_W_Addr),
    .wdata   (W_Data),
    .raddr_a (RF_Ra_Addr),
    .raddr_b (RF_Rb_Addr),
    .rdata_a (Ra_Data),
    .rdata_b (Rb_Data)
  );

  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ZERO:  alu_res = '0;
      ALU_ADD:   alu_res = Ra_Data + Rb_Data;
      ALU_SUB:   alu_res = Ra_Data - Rb_Data;
      ALU_PASSA: alu_res = Ra_Data;
      ALU_XOR:   alu_res = Ra_Data ^ Rb_Data;
      ALU_OR:    alu_res = Ra_Data | Rb_Data;
      ALU_AND:   alu_res = Ra_Data & Rb_Data;
      ALU_INC:   alu_res = Ra_Data + 16'd1;
      default:   alu_res = '0;
    endcase
  end

  assign ALU_Out = alu_res;
  assign W_Data  = RF_s ? q_q : alu_res;

  // Memory contents survive reset; only the write is suppressed while Rst is high.
  always_comb begin
    mem_we = D_Wr && !Rst;
    q_d    = mem[D_Addr];
  end

  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem[D_Addr] <= Ra_Data;
    end
  end

  // Read-first: q_d samples the old word on the same edge a write lands.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

`ifdef DATAPATH_FLAGS_EN
  logic z_q, z_d;
  logic n_q, n_d;
  logic c_q, c_d;
  logic c_calc;

  // Carry/borrow recovered from the 16-bit operands without a widened adder.
  always_comb begin
    c_calc = 1'b0;
    case (alu_op)
      ALU_ADD: c_calc = (alu_res < Ra_Data);
      ALU_SUB: c_calc = (Ra_Data < Rb_Data);
      ALU_INC: c_calc = (Ra_Data == 16'hFFFF);
      default: c_calc = 1'b0;
    endcase
  end

  always_comb begin
    z_d = z_q;
    n_d = n_q;
    c_d = c_q;
    if (RF_W_en && !RF_s) begin
      z_d = (alu_res == '0);
      n_d = alu_res[DW-1];
      c_d = c_calc;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      z_q <= 1'b0;
      n_q <= 1'b0;
      c_q <= 1'b0;
    end else begin
      z_q <= z_d;
      n_q <= n_d;
      c_q <= c_d;
    end
  end

  assign Z = z_q;
  assign N = n_q;
  assign C = c_q;
`endif

endmodule

// File: tb/tb_datapath_unit.sv
// tb/tb_datapath_unit.sv - directed self-checking bench for datapath_unit
// Flag checks are compiled in when DATAPATH_FLAGS_EN is defined.
module tb_datapath_unit;
  import datapath_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [7:0]  D_Addr;
  logic        D_Wr;
  logic        RF_s;
  logic        RF_W_en;
  logic [3:0]  RF_W_Addr;
  logic [3:0]  RF_Ra_Addr;
  logic [3:0]  RF_Rb_Addr;
  logic [2:0]  Alu_s0;
  logic [15:0] Ra_Data;
  logic [15:0] Rb_Data;
  logic [15:0] ALU_Out;
  logic [15:0] W_Data;
`ifdef DATAPATH_FLAGS_EN
  logic        Z;
  logic        N;
  logic        C;
`endif

  int n_cmp = 0;
  int n_err = 0;

  datapath_unit dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .D_Addr     (D_Addr),
    .D_Wr       (D_Wr),
    .RF_s       (RF_s),
    .RF_W_en    (RF_W_en),
    .RF_W_Addr  (RF_W_Addr),
    .RF_Ra_Addr (RF_Ra_Addr),
    .RF_Rb_Addr (RF_Rb_Addr),
    .Alu_s0     (Alu_s0),
    .Ra_Data    (Ra_Data),
    .Rb_Data    (Rb_Data),
    .ALU_Out    (ALU_Out),
    .W_Data     (W_Data)
`ifdef DATAPATH_FLAGS_EN
    ,
    .Z          (Z),
    .N          (N),
    .C          (C)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    D_Addr     = '0;
    D_Wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_en    = 1'b0;
    RF_W_Addr  = '0;
    RF_Ra_Addr = '0;
    RF_Rb_Addr = '0;
    Alu_s0     = ALU_ZERO;
  endtask

  // Builds a constant in register r by doubling (r+r) and incrementing (r+1).
  task automatic load_const(input logic [3:0] r, input logic [15:0] val);
    RF_s       = 1'b0;
    RF_W_en    = 1'b1;
    RF_W_Addr  = r;
    RF_Ra_Addr = r;
    RF_Rb_Addr = r;
    Alu_s0     = ALU_ZERO;
    tick();
    for (int i = 15; i >= 0; i--) begin
      Alu_s0 = ALU_ADD;
      tick();
      if (val[i]) begin
        Alu_s0 = ALU_INC;
        tick();
      end
    end
    RF_W_en = 1'b0;
  endtask

  logic [2:0]  op_tab  [8];
  logic [15:0] exp_tab [8];

  initial begin
    op_tab  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    exp_tab = '{16'h0000, 16'h6789, 16'h4321, 16'h5555,
                16'h4761, 16'h5775, 16'h1014, 16'h5556};

    idle();
    Rst = 1'b1;
    tick();
    tick();
    tick();

    for (int r = 0; r < 16; r++) begin
      RF_Ra_Addr = 4'(r);
      RF_Rb_Addr = 4'(15 - r);
      #0.5;
      check_eq($sformatf("rst_ra_r%0d", r), Ra_Data, 16'h0000);
      check_eq($sformatf("rst_rb_r%0d", r), Rb_Data, 16'h0000);
    end
    Alu_s0 = ALU_ADD;
    RF_s   = 1'b1;
    #0.5;
    check_eq("rst_alu", ALU_Out, 16'h0000);
    check_eq("rst_wdata_q", W_Data, 16'h0000);
`ifdef DATAPATH_FLAGS_EN
    check_eq("rst_flags", {13'b0, Z, N, C}, 16'h0000);
`endif

    @(negedge Clk);
    Rst = 1'b0;
    idle();
    tick();

    // mem[0x1B] = 0x1234 via R1, then reset again with a D_Wr pulse
    load_const(4'd1, 16'h1234);
    RF_Ra_Addr = 4'd1;
    #1;
    check_eq("build_r1", Ra_Data, 16'h1234);
    D_Addr = 8'h1B;
    D_Wr   = 1'b1;
    tick();
    D_Wr = 1'b0;

    Rst = 1'b1;
    #1;
    check_eq("rst_mid_clear_r1", Ra_Data, 16'h0000);
    D_Addr = 8'h1B;
    D_Wr   = 1'b1;
    tick();
    tick();
    tick();
    @(negedge Clk);
    Rst = 1'b0;
    idle();
    tick();

    // load sequence: address cycle, then write-back cycle
    D_Addr = 8'h1B;
    tick();
    RF_s      = 1'b1;
    RF_W_en   = 1'b1;
    RF_W_Addr = 4'd3;
    #1;
    check_eq("load_wdata", W_Data, 16'h1234);
    tick();
    idle();
    RF_Ra_Addr = 4'd3;
    #1;
    check_eq("load_r3", Ra_Data, 16'h1234);

    // add with wrap
    load_const(4'd1, 16'hFFFF);
    load_const(4'd2, 16'h0002);
    RF_Ra_Addr = 4'd1;
    RF_Rb_Addr = 4'd2;
    Alu_s0     = ALU_ADD;
    RF_W_Addr  = 4'd4;
    RF_W_en    = 1'b1;
    #1;
    check_eq("add_wrap_alu", ALU_Out, 16'h0001);
    tick();
    idle();
`ifdef DATAPATH_FLAGS_EN
    check_eq("add_wrap_znc", {13'b0, Z, N, C}, 16'h0001);
`endif
    RF_Ra_Addr = 4'd4;
    #1;
    check_eq("add_wrap_r4", Ra_Data, 16'h0001);

    // subtract to zero
    load_const(4'd5, 16'h00A0);
    load_const(4'd6, 16'h00A0);
    RF_Ra_Addr = 4'd5;
    RF_Rb_Addr = 4'd6;
    Alu_s0     = ALU_SUB;
    RF_W_Addr  = 4'd8;
    RF_W_en    = 1'b1;
    #1;
    check_eq("sub_zero_alu", ALU_Out, 16'h0000);
    tick();
    idle();
`ifdef DATAPATH_FLAGS_EN
    check_eq("sub_zero_znc", {13'b0, Z, N, C}, 16'h0004);
`endif

    // store: mem[0x80]=0x1234, then overwrite with R4 and read-first
    RF_Ra_Addr = 4'd3;
    D_Addr     = 8'h80;
    D_Wr       = 1'b1;
    tick();
    RF_Ra_Addr = 4'd4;
    tick();
    D_Wr = 1'b0;
    RF_s = 1'b1;
    #1;
    check_eq("store_rd_old", W_Data, 16'h1234);
    tick();
    check_eq("store_rd_new", W_Data, 16'h0001);
    idle();

    // ALU op table with A=0x5555 (R9), B=0x1234 (R3)
    load_const(4'd9, 16'h5555);
    RF_Ra_Addr = 4'd9;
    RF_Rb_Addr = 4'd3;
    for (int k = 0; k < 8; k++) begin
      Alu_s0 = op_tab[k];
      #0.5;
      check_eq($sformatf("alu_op%0d", k), ALU_Out, exp_tab[k]);
    end

    // negative result with borrow
    tick();
    RF_Ra_Addr = 4'd3;
    RF_Rb_Addr = 4'd9;
    Alu_s0     = ALU_SUB;
    RF_W_Addr  = 4'd10;
    RF_W_en    = 1'b1;
    #1;
    check_eq("sub_neg_alu", ALU_Out, 16'hBCDF);
    tick();
`ifdef DATAPATH_FLAGS_EN
    check_eq("sub_neg_znc", {13'b0, Z, N, C}, 16'h0003);
    // flags hold without an ALU write-back
    RF_W_en    = 1'b0;
    RF_Ra_Addr = 4'd5;
    RF_Rb_Addr = 4'd6;
    tick();
    check_eq("flags_hold", {13'b0, Z, N, C}, 16'h0003);
    // increment carry out of 0xFFFF
    RF_Ra_Addr = 4'd1;
    Alu_s0     = ALU_INC;
    RF_W_Addr  = 4'd11;
    RF_W_en    = 1'b1;
    tick();
    check_eq("inc_carry_znc", {13'b0, Z, N, C}, 16'h0005);
`endif
    idle();

    // same-address read/write on R7
    RF_Ra_Addr = 4'd7;
    RF_W_Addr  = 4'd7;
    RF_W_en    = 1'b1;
    Alu_s0     = ALU_ZERO;
    tick();
    RF_Rb_Addr = 4'd9;
    Alu_s0     = ALU_OR;
    #1;
    check_eq("rw_same_old", Ra_Data, 16'h0000);
    check_eq("rw_same_wdata", W_Data, 16'h5555);
    tick();
    RF_W_en = 1'b0;
    #1;
    check_eq("rw_same_new", Ra_Data, 16'h5555);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
